// File: rtl/fifo_word_packer_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg : shared constants and state type for the byte-FIFO word packer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

   localparam int DATA_W               = 8;
   localparam int FIFO_DEPTH           = 64;
   localparam int PACK_BYTES           = 4;
   localparam int FLUSH_CYCLES_DEFAULT = 16;
   localparam int HELD_W               = $clog2(PACK_BYTES + 1);
   localparam int LANE_W               = $clog2(PACK_BYTES);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      OUT  = 1'b1
   } pack_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_word_packer_if.sv
// ----------------------------------------------------------------------------
// fifo_word_packer_if : FIFO read port plus packed-word valid/ready bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface fifo_word_packer_if import fifo_pkg::*; ();

   logic                          buf_empt;
   logic [DATA_W-1:0]             buf_out;
   logic                          rd_en;
   logic [PACK_BYTES*DATA_W-1:0]  word_out;
   logic [PACK_BYTES-1:0]         word_keep;
   logic                          word_valid;
   logic                          word_ready;
   logic [15:0]                   words_sent;

   modport master (
      input  buf_empt, buf_out, word_ready,
      output rd_en, word_out, word_keep, word_valid, words_sent
   );

   modport slave (
      output buf_empt, buf_out, word_ready,
      input  rd_en, word_out, word_keep, word_valid, words_sent
   );

endinterface

`default_nettype wire

// File: rtl/fifo_word_packer_assembler.sv
// ----------------------------------------------------------------------------
// byte_lane_assembler : 4-lane byte register with indexed write, clear, keep mask
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module byte_lane_assembler import fifo_pkg::*; (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   input  logic                          wr_en,
   input  logic [LANE_W-1:0]             wr_lane,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic [HELD_W-1:0]             keep_cnt,
   output logic [PACK_BYTES*DATA_W-1:0]  word,
   output logic [PACK_BYTES-1:0]         keep
);

   logic [PACK_BYTES-1:0][DATA_W-1:0] lanes_q, lanes_d;

   always_comb begin
      lanes_d = lanes_q;
      if (clr) begin
         lanes_d = '0;
      end else if (wr_en) begin
         lanes_d[wr_lane] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lanes_q <= '0;
      end else begin
         lanes_q <= lanes_d;
      end
   end

   assign word = lanes_q;

   // Lane i is valid once more than i bytes have been collected.
   generate
      for (genvar i = 0; i < PACK_BYTES; i++) begin : g_keep
         assign keep[i] = (keep_cnt > HELD_W'(i));
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/fifo_word_packer.sv
// ----------------------------------------------------------------------------
// fifo_word_packer : drains a byte FIFO into little-endian 32-bit words.
// Optional partial-word flush on idle timeout: PACK_FLUSH_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_word_packer import fifo_pkg::*; #(
   parameter int BYTES        = PACK_BYTES,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   fifo_word_packer_if.master bus
);

   generate
      if (BYTES != PACK_BYTES || FLUSH_CYCLES < 1) begin : g_param_check
         $error("fifo_word_packer: BYTES must equal PACK_BYTES and FLUSH_CYCLES must be >= 1");
      end
   endgenerate

   pack_state_t         state_q, state_d;
   logic [HELD_W-1:0]   held_q, held_d;
   logic                inflight_q, inflight_d;
   logic [15:0]         words_sent_q, words_sent_d;

   logic                w_rd_en;
   logic                w_capture;
   logic                w_accept;
   logic                w_valid;
   logic                w_flush;
   logic [HELD_W:0]     w_pending;
   logic [PACK_BYTES-1:0] w_keep_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= FILL;
         held_q       <= '0;
         inflight_q   <= 1'b0;
         words_sent_q <= '0;
      end else begin
         state_q      <= state_d;
         held_q       <= held_d;
         inflight_q   <= inflight_d;
         words_sent_q <= words_sent_d;
      end
   end

   // Reads are budgeted against bytes held plus the one still in flight so a
   // fifth byte is never popped. rd_en is also masked while reset is active.
   always_comb begin
      w_pending = {1'b0, held_q} + (HELD_W+1)'(inflight_q);
      w_valid   = (state_q == OUT);
      w_rd_en   = !rst && (state_q == FILL) && !bus.buf_empt &&
                  (w_pending < (HELD_W+1)'(BYTES));
      w_capture = (state_q == FILL) && inflight_q;
      w_accept  = w_valid && bus.word_ready;
   end

   always_comb begin
      state_d      = state_q;
      held_d       = held_q;
      inflight_d   = w_rd_en;
      words_sent_d = words_sent_q;
      case (state_q)
         FILL: begin
            if (w_capture) begin
               held_d = held_q + HELD_W'(1);
            end
            if (held_d == HELD_W'(BYTES) || w_flush) begin
               state_d = OUT;
            end
         end
         OUT: begin
            if (w_accept) begin
               held_d       = '0;
               words_sent_d = words_sent_q + 16'd1;
               state_d      = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

`ifdef PACK_FLUSH_EN
   localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);

   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              w_idle;

   always_comb begin
      w_idle  = (state_q == FILL) && (held_q != '0) && (held_q < HELD_W'(BYTES)) &&
                !inflight_q && bus.buf_empt;
      idle_d  = w_idle ? idle_q + IDLE_W'(1) : '0;
      w_flush = w_idle && (idle_q == IDLE_W'(FLUSH_CYCLES - 1));
      if (w_flush) begin
         idle_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   assign w_flush = 1'b0;
`endif

   byte_lane_assembler u_lanes (
      .clk      (clk),
      .rst      (rst),
      .clr      (w_accept),
      .wr_en    (w_capture),
      .wr_lane  (held_q[LANE_W-1:0]),
      .wr_data  (bus.buf_out),
      .keep_cnt (held_q),
      .word     (bus.word_out),
      .keep     (w_keep_mask)
   );

   assign bus.rd_en      = w_rd_en;
   assign bus.word_valid = w_valid;
   assign bus.word_keep  = w_valid ? w_keep_mask : '0;
   assign bus.words_sent = words_sent_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// ----------------------------------------------------------------------------
// tb_fifo_word_packer : directed self-checking bench with a behavioural byte FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_word_packer;
   import fifo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic gap = 1'b0;

   always #5 clk = ~clk;

   fifo_word_packer_if bus ();

   fifo_word_packer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural FIFO: one-cycle read latency, empty flag follows pointers.
   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;

   assign bus.buf_empt = (wr_ptr == rd_ptr) || gap;

   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.buf_out <= mem[rd_ptr[7:0]];
         rd_ptr      <= rd_ptr + 1;
      end
   end

   int checks = 0;
   int passed = 0;

   task automatic push(input logic [7:0] b);
      mem[wr_ptr[7:0]] = b;
      wr_ptr++;
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst            = 1'b1;
      bus.word_ready = 1'b0;
      gap            = 1'b0;
      tick();
      tick();
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic wait_valid(input int budget, output int n, output bit seen);
      seen = 1'b0;
      n    = 0;
      while (!seen && n < budget) begin
         if (bus.word_valid) seen = 1'b1;
         else begin
            tick();
            n++;
         end
      end
   endtask

   task automatic test_reset;
      rst            = 1'b1;
      bus.word_ready = 1'b0;
      tick();
      checks++; if (bus.rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", bus.rd_en); else passed++;
      checks++; if (bus.word_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.word_valid); else passed++;
      checks++; if (bus.word_out !== 32'h0) $display("FAIL reset_word: got %h expected 00000000", bus.word_out); else passed++;
      checks++; if (bus.word_keep !== 4'h0) $display("FAIL reset_keep: got %h expected 0", bus.word_keep); else passed++;
      checks++; if (bus.words_sent !== 16'h0) $display("FAIL reset_count: got %h expected 0000", bus.words_sent); else passed++;
   endtask

   task automatic test_basic;
      int rd_cnt = 0, first = -1, last = -1, vld = -1;
      logic [31:0] w = 'x;
      logic [3:0]  k = 'x;
      do_reset();
      bus.word_ready = 1'b1;
      @(negedge clk);
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      #1;
      for (int i = 0; i < 12; i++) begin
         if (bus.rd_en) begin
            rd_cnt++;
            if (first < 0) first = i;
            last = i;
         end
         if (bus.word_valid && vld < 0) begin
            vld = i;
            w   = bus.word_out;
            k   = bus.word_keep;
         end
         tick();
      end
      checks++; if (rd_cnt != 4) $display("FAIL basic_rd_count: got %0d expected 4", rd_cnt); else passed++;
      checks++; if (first != 0 || last != 3) $display("FAIL basic_rd_window: got %0d..%0d expected 0..3", first, last); else passed++;
      checks++; if (vld != 5) $display("FAIL basic_latency: got %0d expected 5", vld); else passed++;
      checks++; if (w !== 32'h04030201) $display("FAIL basic_word: got %h expected 04030201", w); else passed++;
      checks++; if (k !== 4'hF) $display("FAIL basic_keep: got %h expected f", k); else passed++;
      checks++; if (bus.words_sent !== 16'd1) $display("FAIL basic_count: got %0d expected 1", bus.words_sent); else passed++;
   endtask

   task automatic test_backpressure;
      int n;
      bit seen;
      int stable_bad = 0, rd_bad = 0;
      do_reset();
      @(negedge clk);
      for (int b = 8'h11; b <= 8'h18; b++) push(8'(b));
      #1;
      wait_valid(20, n, seen);
      checks++; if (!seen || bus.word_out !== 32'h14131211) $display("FAIL bp_first_word: got %h (valid %b) expected 14131211", bus.word_out, seen); else passed++;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.word_out !== 32'h14131211 || bus.word_valid !== 1'b1) stable_bad++;
         if (bus.rd_en !== 1'b0) rd_bad++;
      end
      checks++; if (stable_bad != 0) $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_bad); else passed++;
      checks++; if (rd_bad != 0) $display("FAIL bp_rd_en: got %0d read cycles expected 0", rd_bad); else passed++;
      checks++; if (bus.words_sent !== 16'd0) $display("FAIL bp_count_stall: got %0d expected 0", bus.words_sent); else passed++;
      bus.word_ready = 1'b1;
      tick();
      wait_valid(20, n, seen);
      checks++; if (!seen || bus.word_out !== 32'h18171615) $display("FAIL bp_second_word: got %h (valid %b) expected 18171615", bus.word_out, seen); else passed++;
      tick();
      checks++; if (bus.words_sent !== 16'd2) $display("FAIL bp_count: got %0d expected 2", bus.words_sent); else passed++;
   endtask

   task automatic test_partial;
      int n;
      bit seen;
      int vld = -1;
      logic [31:0] w = 'x;
      logic [3:0]  k = 'x;
      do_reset();
      bus.word_ready = 1'b1;
      @(negedge clk);
      push(8'hAA); push(8'hBB);
      #1;
      for (int i = 0; i < 30; i++) begin
         if (bus.word_valid && vld < 0) begin
            vld = i;
            w   = bus.word_out;
            k   = bus.word_keep;
         end
         tick();
      end
`ifdef PACK_FLUSH_EN
      // AA/BB captured by cycle 2; 16 idle cycles (3..18) then valid in cycle 19.
      checks++; if (vld != 19) $display("FAIL flush_time: got %0d expected 19", vld); else passed++;
      checks++; if (w !== 32'h0000BBAA) $display("FAIL flush_word: got %h expected 0000bbaa", w); else passed++;
      checks++; if (k !== 4'b0011) $display("FAIL flush_keep: got %b expected 0011", k); else passed++;
      checks++; if (bus.words_sent !== 16'd1) $display("FAIL flush_count: got %0d expected 1", bus.words_sent); else passed++;
`else
      checks++; if (vld != -1) $display("FAIL partial_no_valid: got valid at %0d expected none", vld); else passed++;
      @(negedge clk);
      push(8'hCC); push(8'hDD);
      #1;
      wait_valid(20, n, seen);
      checks++; if (!seen || bus.word_out !== 32'hDDCCBBAA) $display("FAIL partial_word: got %h (valid %b) expected ddccbbaa", bus.word_out, seen); else passed++;
      checks++; if (bus.word_keep !== 4'hF) $display("FAIL partial_keep: got %h expected f", bus.word_keep); else passed++;
      tick();
      checks++; if (bus.words_sent !== 16'd1) $display("FAIL partial_count: got %0d expected 1", bus.words_sent); else passed++;
`endif
   endtask

   task automatic test_toggle;
      bit seen = 1'b0;
      int bad = 0;
      logic [31:0] w = 'x;
      do_reset();
      bus.word_ready = 1'b1;
      @(negedge clk);
      push(8'h31); push(8'h32); push(8'h33); push(8'h34);
      gap = 1'b1;
      #1;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (bus.rd_en && bus.buf_empt) bad++;
         if (bus.word_valid) begin
            seen = 1'b1;
            w    = bus.word_out;
            if (bus.rd_en) bad++;
         end else begin
            @(negedge clk);
            gap = ~gap;
            #1;
         end
      end
      gap = 1'b0;
      checks++; if (!seen) $display("FAIL toggle_timeout: got no valid expected valid within 40 cycles"); else passed++;
      checks++; if (w !== 32'h34333231) $display("FAIL toggle_word: got %h expected 34333231", w); else passed++;
      checks++; if (bad != 0) $display("FAIL toggle_rd_en: got %0d illegal reads expected 0", bad); else passed++;
      tick();
      checks++; if (bus.words_sent !== 16'd1) $display("FAIL toggle_count: got %0d expected 1", bus.words_sent); else passed++;
   endtask

   task automatic test_reset_mid;
      int n;
      bit seen;
      do_reset();
      bus.word_ready = 1'b1;
      @(negedge clk);
      push(8'h51); push(8'h52);
      #1;
      tick(); tick(); tick();
      @(negedge clk);
      rst = 1'b1;
      push(8'h21); push(8'h22); push(8'h23); push(8'h24);
      #1;
      checks++; if (bus.rd_en !== 1'b0) $display("FAIL midrst_rd_en: got %b expected 0", bus.rd_en); else passed++;
      checks++; if (bus.word_out !== 32'h0) $display("FAIL midrst_word: got %h expected 00000000", bus.word_out); else passed++;
      checks++; if (bus.word_valid !== 1'b0 || bus.word_keep !== 4'h0) $display("FAIL midrst_valid_keep: got %b/%h expected 0/0", bus.word_valid, bus.word_keep); else passed++;
      tick();
      @(negedge clk);
      rst = 1'b0;
      #1;
      wait_valid(20, n, seen);
      checks++; if (!seen || bus.word_out !== 32'h24232221) $display("FAIL midrst_next_word: got %h (valid %b) expected 24232221", bus.word_out, seen); else passed++;
      tick();
      checks++; if (bus.words_sent !== 16'd1) $display("FAIL midrst_count: got %0d expected 1", bus.words_sent); else passed++;
   endtask

   task automatic test_wrap;
      int n;
      bit seen;
      do_reset();
      bus.word_ready = 1'b1;
      @(negedge clk);
      force dut.words_sent_q = 16'hFFFF;
      #1;
      release dut.words_sent_q;
      tick();
      checks++; if (bus.words_sent !== 16'hFFFF) $display("FAIL wrap_hold: got %h expected ffff", bus.words_sent); else passed++;
      @(negedge clk);
      push(8'h61); push(8'h62); push(8'h63); push(8'h64);
      #1;
      wait_valid(20, n, seen);
      checks++; if (!seen || bus.word_out !== 32'h64636261) $display("FAIL wrap_word: got %h (valid %b) expected 64636261", bus.word_out, seen); else passed++;
      tick();
      checks++; if (bus.words_sent !== 16'h0000) $display("FAIL wrap_count: got %h expected 0000", bus.words_sent); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_partial();
      test_toggle();
      test_reset_mid();
      test_wrap();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
